// File: rtl/fir_mac_seq_if.sv
// Sample, coefficient-write and result signals of the sequential FIR MAC.
// The master drives samples and coefficients; the slave is the filter.
interface fir_mac_seq_if #(
    parameter int unsigned NUM_BITS = 16,
    parameter int unsigned NUM_TAPS = 4,
    parameter int unsigned ACC_BITS = 2 * NUM_BITS + $clog2(NUM_TAPS)
);
    logic                         sample_valid;
    logic signed [NUM_BITS-1:0]   sample_in;
    logic                         sample_ready;
    logic                         coeff_we;
    logic [$clog2(NUM_TAPS)-1:0]  coeff_addr;
    logic signed [NUM_BITS-1:0]   coeff_in;
    logic signed [ACC_BITS-1:0]   result;
    logic                         result_valid;
    logic                         busy;

    modport master (
        output sample_valid, sample_in, coeff_we, coeff_addr, coeff_in,
        input  sample_ready, result, result_valid, busy
    );

    modport slave (
        input  sample_valid, sample_in, coeff_we, coeff_addr, coeff_in,
        output sample_ready, result, result_valid, busy
    );
endinterface

// File: rtl/fir_mac_seq.sv
// Sequential FIR filter: one multiply-accumulate per cycle over NUM_TAPS taps,
// producing one full-precision result per accepted sample.
module fir_mac_seq #(
    parameter int unsigned NUM_BITS = 16,
    parameter int unsigned NUM_TAPS = 4,
    parameter int unsigned ACC_BITS = 2 * NUM_BITS + $clog2(NUM_TAPS)
) (
    input logic           clk,
    input logic           n_reset,
    fir_mac_seq_if.slave  bus
);
    localparam int unsigned IdxBits  = $clog2(NUM_TAPS);
    localparam int unsigned ProdBits = 2 * NUM_BITS;
    localparam logic [IdxBits-1:0] LastIdx  = IdxBits'(NUM_TAPS - 1);
    localparam logic [IdxBits:0]   TapCount = (IdxBits + 1)'(NUM_TAPS);

    typedef enum logic [1:0] {StIdle, StMac, StDone} state_e;

    state_e                     state_q, state_d;
    logic [IdxBits-1:0]         idx_q, idx_d;
    logic signed [ACC_BITS-1:0] acc_q, acc_d;
    logic signed [ACC_BITS-1:0] result_q, result_d;
    logic                       result_valid_q, result_valid_d;
    logic signed [NUM_BITS-1:0] tap_q [NUM_TAPS];
    logic signed [NUM_BITS-1:0] tap_d [NUM_TAPS];
    logic signed [NUM_BITS-1:0] coeff_q [NUM_TAPS];
    logic signed [NUM_BITS-1:0] coeff_d [NUM_TAPS];
    logic signed [ProdBits-1:0] prod;
    logic                       accept;
    logic                       coeff_wr;

    assign accept   = (state_q == StIdle) && bus.sample_valid;
    // Out-of-range addresses only exist for non-power-of-two tap counts.
    assign coeff_wr = (state_q == StIdle) && bus.coeff_we
                      && ({1'b0, bus.coeff_addr} < TapCount);

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        acc_d          = acc_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        tap_d          = tap_q;
        coeff_d        = coeff_q;
        prod           = tap_q[idx_q] * coeff_q[idx_q];

        if (coeff_wr) begin
            coeff_d[bus.coeff_addr] = bus.coeff_in;
        end

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    tap_d[0] = bus.sample_in;
                    for (int k = 1; k < NUM_TAPS; k++) begin
                        tap_d[k] = tap_q[k-1];
                    end
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = StMac;
                end
            end
            StMac: begin
                acc_d = acc_q + {{(ACC_BITS - ProdBits){prod[ProdBits-1]}}, prod};
                idx_d = idx_q + 1'b1;
                if (idx_q == LastIdx) begin
                    idx_d   = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                result_d       = acc_q;
                result_valid_d = 1'b1;
                state_d        = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q        <= StIdle;
            idx_q          <= '0;
            acc_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            for (int k = 0; k < NUM_TAPS; k++) begin
                tap_q[k]   <= '0;
                coeff_q[k] <= '0;
            end
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            acc_q          <= acc_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            tap_q          <= tap_d;
            coeff_q        <= coeff_d;
        end
    end

    assign bus.sample_ready = (state_q == StIdle);
    assign bus.busy         = (state_q != StIdle);
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
endmodule

// File: tb/tb_fir_mac_seq.sv
// Self-checking bench for fir_mac_seq: table-driven samples plus directed
// corner sequences, with a cycle-stamped scoreboard of expected results.
module tb_fir_mac_seq;
    localparam int NB = 16;
    localparam int NT = 4;

    logic clk = 1'b0;
    logic n_reset = 1'b0;

    fir_mac_seq_if #(.NUM_BITS(NB), .NUM_TAPS(NT)) bus ();

    fir_mac_seq #(.NUM_BITS(NB), .NUM_TAPS(NT)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { longint value; int at_cyc; } exp_t;
    typedef struct { longint sample; longint exp; } vec_t;

    exp_t   sb [$];
    exp_t   mon_e;
    longint m_tap   [NT];
    longint m_coeff [NT];
    vec_t   tab     [8];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Each result must arrive exactly at its stamped cycle with the model value.
    always @(negedge clk) begin
        if (bus.result_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result_valid: got pulse with result %0d at cycle %0d, expected none",
                         bus.result, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("result", bus.result, mon_e.value);
                check("result_latency", cyc, mon_e.at_cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic model_clear();
        for (int k = 0; k < NT; k++) begin
            m_tap[k]   = 0;
            m_coeff[k] = 0;
        end
        sb.delete();
    endtask

    task automatic do_reset();
        n_reset = 1'b0;
        idle(2);
        n_reset = 1'b1;
        model_clear();
    endtask

    task automatic write_coeff(input int addr, input longint c);
        bus.coeff_we   = 1'b1;
        bus.coeff_addr = 2'(addr);
        bus.coeff_in   = 16'(c);
        tick();
        m_coeff[addr]  = c;
        bus.coeff_we   = 1'b0;
    endtask

    // Called at the negedge right after the accepting edge.
    task automatic model_accept(input longint s, input bit use_tab, input longint tab_exp);
        longint sum;
        for (int k = NT - 1; k > 0; k--) m_tap[k] = m_tap[k-1];
        m_tap[0] = s;
        sum = 0;
        for (int k = 0; k < NT; k++) sum += m_tap[k] * m_coeff[k];
        sb.push_back('{value: (use_tab ? tab_exp : sum), at_cyc: cyc + NT + 1});
    endtask

    task automatic do_accept(input longint s, input bit we, input int addr, input longint c,
                             input bit use_tab, input longint tab_exp);
        bus.sample_valid = 1'b1;
        bus.sample_in    = 16'(s);
        bus.coeff_we     = we;
        bus.coeff_addr   = 2'(addr);
        bus.coeff_in     = 16'(c);
        check("sample_ready_before_accept", bus.sample_ready, 1);
        tick();
        if (we) m_coeff[addr] = c;
        model_accept(s, use_tab, tab_exp);
        bus.sample_valid = 1'b0;
        bus.coeff_we     = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tab[0] = '{sample: 1,   exp: 1};
        tab[1] = '{sample: 0,   exp: 2};
        tab[2] = '{sample: 0,   exp: 3};
        tab[3] = '{sample: 0,   exp: 4};
        tab[4] = '{sample: 10,  exp: 10};
        tab[5] = '{sample: -3,  exp: 17};
        tab[6] = '{sample: 100, exp: 124};
        tab[7] = '{sample: -1,  exp: 230};

        bus.sample_valid = 1'b0;
        bus.sample_in    = '0;
        bus.coeff_we     = 1'b0;
        bus.coeff_addr   = '0;
        bus.coeff_in     = '0;
        @(negedge clk);
        do_reset();
        check("reset_sample_ready", bus.sample_ready, 1);
        check("reset_busy", bus.busy, 0);
        check("reset_result_valid", bus.result_valid, 0);
        check("reset_result", bus.result, 0);

        // Impulse response and mixed samples, back-to-back at 6-cycle spacing.
        for (int k = 0; k < NT; k++) write_coeff(k, k + 1);
        for (int i = 0; i < 8; i++) begin
            do_accept(tab[i].sample, 1'b0, 0, 0, 1'b1, tab[i].exp);
            idle(2);
            check("busy_in_mac", bus.busy, 1);
            check("not_ready_in_mac", bus.sample_ready, 0);
            idle(3);
        end
        idle(3);
        check("result_hold", bus.result, 230);
        check("result_valid_low_when_idle", bus.result_valid, 0);

        // Most negative samples and coefficients.
        do_reset();
        for (int k = 0; k < NT; k++) write_coeff(k, -32768);
        for (int i = 0; i < NT; i++) begin
            do_accept(-32768, 1'b0, 0, 0, 1'b0, 0);
            idle(5);
        end
        check("extreme_final", bus.result, 64'sd4294967296);

        // sample_valid held high: only IDLE cycles accept.
        do_reset();
        for (int k = 0; k < NT; k++) write_coeff(k, k + 1);
        bus.sample_valid = 1'b1;
        bus.sample_in    = 16'sd7;
        for (int k = 0; k < 18; k++) begin
            check("busy_drop_ready", bus.sample_ready, (k % 6 == 0) ? 1 : 0);
            tick();
            if (k % 6 == 0) model_accept(7, 1'b0, 0);
        end
        bus.sample_valid = 1'b0;
        idle(6);
        check("busy_drop_final", bus.result, 42);

        // Coefficient write racing a sample accept, then a write during MAC.
        do_reset();
        do_accept(3, 1'b1, 0, 5, 1'b0, 0);
        idle(2);
        bus.coeff_we   = 1'b1;
        bus.coeff_addr = 2'd1;
        bus.coeff_in   = 16'sd9;
        tick();
        bus.coeff_we   = 1'b0;
        idle(2);
        check("coeff_race_result", bus.result, 15);
        do_accept(2, 1'b0, 0, 0, 1'b0, 0);
        idle(5);
        check("coeff_write_in_mac_ignored", bus.result, 10);

        // Reset in the second MAC cycle aborts the computation.
        do_reset();
        write_coeff(0, 2);
        do_accept(5, 1'b0, 0, 0, 1'b0, 0);
        tick();
        n_reset = 1'b0;
        tick();
        n_reset = 1'b1;
        model_clear();
        check("abort_sample_ready", bus.sample_ready, 1);
        check("abort_busy", bus.busy, 0);
        check("abort_result_valid", bus.result_valid, 0);
        check("abort_result", bus.result, 0);
        idle(6);
        do_accept(4, 1'b0, 0, 0, 1'b0, 0);
        idle(5);
        check("abort_coeffs_cleared", bus.result, 0);
        for (int k = 0; k < NT; k++) write_coeff(k, 1);
        do_accept(0, 1'b0, 0, 0, 1'b0, 0);
        idle(5);
        check("abort_taps_cleared", bus.result, 4);

        // A low pulse between edges must not reset anything.
        #2 n_reset = 1'b0;
        #2 n_reset = 1'b1;
        @(negedge clk);
        check("glitch_result_kept", bus.result, 4);
        check("glitch_ready", bus.sample_ready, 1);
        do_accept(0, 1'b0, 0, 0, 1'b0, 0);
        idle(5);
        check("glitch_state_kept", bus.result, 4);

        idle(3);
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
